// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline control unit:
// stall encodings, stage indices and jump FSM states.
package pipe_ctrl_pkg;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    localparam logic [5:0] STALL_BUS  = 6'b011111;
    localparam logic [5:0] STALL_EXE  = 6'b001111;
    localparam logic [5:0] STALL_LU   = 6'b000111;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    localparam int ZERO_REG = 0;

    typedef enum logic {
        S_IDLE,
        S_PEND
    } jstate_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/control bundle between the pipeline and pipe_ctrl.
// master drives the pipeline-side status, slave is the control unit.
interface pipe_ctrl_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int RADDR_WIDTH = 5,
    parameter int CNT_WIDTH   = 32
);
    logic                   ex_is_load_i;
    logic [RADDR_WIDTH-1:0] ex_rd_i;
    logic [RADDR_WIDTH-1:0] id_rs1_i;
    logic [RADDR_WIDTH-1:0] id_rs2_i;
    logic                   id_rs1_re_i;
    logic                   id_rs2_re_i;
    logic                   ex_busy_i;
    logic                   mem_req_i;
    logic                   mem_ack_i;
    logic                   jump_req_i;
    logic [ADDR_WIDTH-1:0]  jump_addr_i;
    logic [5:0]             stall_o;
    logic                   flush_jump_o;
    logic                   jump_o;
    logic [ADDR_WIDTH-1:0]  jump_addr_o;
    logic                   timeout_err_o;
    logic [CNT_WIDTH-1:0]   stall_cnt_o;

    modport master (
        output ex_is_load_i, ex_rd_i, id_rs1_i, id_rs2_i,
        output id_rs1_re_i, id_rs2_re_i, ex_busy_i,
        output mem_req_i, mem_ack_i, jump_req_i, jump_addr_i,
        input  stall_o, flush_jump_o, jump_o, jump_addr_o,
        input  timeout_err_o, stall_cnt_o
    );

    modport slave (
        input  ex_is_load_i, ex_rd_i, id_rs1_i, id_rs2_i,
        input  id_rs1_re_i, id_rs2_re_i, ex_busy_i,
        input  mem_req_i, mem_ack_i, jump_req_i, jump_addr_i,
        output stall_o, flush_jump_o, jump_o, jump_addr_o,
        output timeout_err_o, stall_cnt_o
    );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EXE
// and the source operands of the instruction in ID.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int RADDR_WIDTH = 5
) (
    input  logic                   i_ex_is_load,
    input  logic [RADDR_WIDTH-1:0] i_ex_rd,
    input  logic [RADDR_WIDTH-1:0] i_id_rs1,
    input  logic [RADDR_WIDTH-1:0] i_id_rs2,
    input  logic                   i_rs1_re,
    input  logic                   i_rs2_re,
    output logic                   o_load_use
);

    logic w_rd_nz;
    logic w_hit1;
    logic w_hit2;

    // x0 is never written, so a load to it cannot create a hazard
    assign w_rd_nz = (i_ex_rd != RADDR_WIDTH'(ZERO_REG));
    assign w_hit1  = i_rs1_re & (i_id_rs1 == i_ex_rd);
    assign w_hit2  = i_rs2_re & (i_id_rs2 == i_ex_rd);

    assign o_load_use = i_ex_is_load & w_rd_nz & (w_hit1 | w_hit2);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/control unit: stall vector, jump flush,
// deferred jumps, bus-wait timeout and stall-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int RADDR_WIDTH = 5,
    parameter int TIMEOUT     = 255,
    parameter int CNT_WIDTH   = 32
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    pipe_ctrl_if.slave  bus
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    jstate_t               r_state;
    logic [ADDR_WIDTH-1:0] r_tgt;
    logic [TW-1:0]         r_tcnt;
    logic                  r_err;
    logic [CNT_WIDTH-1:0]  r_scnt;

    logic                  w_mem_wait;
    logic                  w_ds;
    logic                  w_lu;
    logic                  w_issue;
    logic [5:0]            w_stall;
    logic [ADDR_WIDTH-1:0] w_jaddr;

    hazard_detect #(
        .RADDR_WIDTH (RADDR_WIDTH)
    ) u_hazard (
        .i_ex_is_load (bus.ex_is_load_i),
        .i_ex_rd      (bus.ex_rd_i),
        .i_id_rs1     (bus.id_rs1_i),
        .i_id_rs2     (bus.id_rs2_i),
        .i_rs1_re     (bus.id_rs1_re_i),
        .i_rs2_re     (bus.id_rs2_re_i),
        .o_load_use   (w_lu)
    );

    assign w_mem_wait = bus.mem_req_i & ~bus.mem_ack_i;
    assign w_ds       = w_mem_wait | bus.ex_busy_i;

    // A fresh request is the newest target, so it beats a pending one
    assign w_issue = rst_n_i & ~w_ds
                   & (bus.jump_req_i | (r_state == S_PEND));
    assign w_jaddr = bus.jump_req_i ? bus.jump_addr_i : r_tgt;

    always_comb begin
        w_stall = STALL_NONE;
        if (w_mem_wait) begin
            w_stall = STALL_BUS;
        end else if (bus.ex_busy_i) begin
            w_stall = STALL_EXE;
        end else if (w_lu & ~w_issue) begin
            w_stall = STALL_LU;
        end
    end

    assign bus.stall_o       = w_stall;
    assign bus.jump_o        = w_issue;
    assign bus.flush_jump_o  = w_issue;
    assign bus.jump_addr_o   = w_jaddr;
    assign bus.timeout_err_o = r_err;
    assign bus.stall_cnt_o   = r_scnt;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_tgt   <= '0;
            r_tcnt  <= '0;
            r_err   <= 1'b0;
            r_scnt  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.jump_req_i && w_ds) begin
                        r_tgt   <= bus.jump_addr_i;
                        r_state <= S_PEND;
                    end
                end
                S_PEND: begin
                    if (!w_ds) begin
                        r_state <= S_IDLE;
                    end else if (bus.jump_req_i) begin
                        r_tgt <= bus.jump_addr_i;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_mem_wait) begin
                if (r_tcnt != TMAX) begin
                    r_tcnt <= r_tcnt + 1'b1;
                end
                if (r_tcnt == TMAX - 1'b1) begin
                    r_err <= 1'b1;
                end
            end else begin
                r_tcnt <= '0;
            end

            if (w_stall != STALL_NONE && r_scnt != '1) begin
                r_scnt <= r_scnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios
// plus randomized traffic against a behavioural model.
module tb_pipe_ctrl;

    localparam int AW = 32;
    localparam int RW = 5;
    localparam int CW = 32;
    localparam int TO = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.ADDR_WIDTH(AW), .RADDR_WIDTH(RW), .CNT_WIDTH(CW)) bus();

    pipe_ctrl #(
        .ADDR_WIDTH (AW),
        .RADDR_WIDTH(RW),
        .TIMEOUT    (TO),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    bit          m_pend;
    logic [31:0] m_tgt;
    int          m_run;
    bit          m_err;
    longint      m_cnt;
    bit          e_wait;
    bit          e_ds;
    logic [5:0]  e_stall;
    bit          e_jump;
    logic [31:0] e_addr;

    task automatic idle_in();
        bus.ex_is_load_i = 1'b0;
        bus.ex_rd_i      = '0;
        bus.id_rs1_i     = '0;
        bus.id_rs2_i     = '0;
        bus.id_rs1_re_i  = 1'b0;
        bus.id_rs2_re_i  = 1'b0;
        bus.ex_busy_i    = 1'b0;
        bus.mem_req_i    = 1'b0;
        bus.mem_ack_i    = 1'b0;
        bus.jump_req_i   = 1'b0;
        bus.jump_addr_i  = '0;
    endtask

    // Reference: priority rules straight from the stall/jump description
    task automatic model_eval();
        bit lu;
        e_wait = bus.mem_req_i && !bus.mem_ack_i;
        e_ds   = e_wait || bus.ex_busy_i;
        lu = bus.ex_is_load_i && bus.ex_rd_i != 0 &&
             ((bus.id_rs1_re_i && bus.id_rs1_i == bus.ex_rd_i) ||
              (bus.id_rs2_re_i && bus.id_rs2_i == bus.ex_rd_i));
        e_jump = rst_n && !e_ds && (bus.jump_req_i || m_pend);
        e_addr = bus.jump_req_i ? bus.jump_addr_i : m_tgt;
        if (e_wait) e_stall = 6'd31;
        else if (bus.ex_busy_i) e_stall = 6'd15;
        else if (lu && !e_jump) e_stall = 6'd7;
        else e_stall = 6'd0;
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        if (!rst_n) begin
            m_pend = 0; m_tgt = 0; m_run = 0; m_err = 0; m_cnt = 0;
        end else begin
            if (e_ds && bus.jump_req_i) begin
                m_pend = 1; m_tgt = bus.jump_addr_i;
            end else if (!e_ds) begin
                m_pend = 0;
            end
            m_run = e_wait ? m_run + 1 : 0;
            if (m_run >= TO) m_err = 1;
            if (e_stall != 0 && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.mem_req_i = 1'b1;
        bus.jump_req_i = 1'b1;
        bus.jump_addr_i = 32'h44;
        #1;
        checks++;
        if (bus.stall_o !== 6'b011111) begin
            errors++;
            $display("FAIL rst_stall got %b exp 011111", bus.stall_o);
        end
        checks++;
        if (bus.jump_o !== 1'b0 || bus.flush_jump_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_jump_gate got %b%b exp 00",
                     bus.jump_o, bus.flush_jump_o);
        end
        tick();
        checks++;
        if (bus.stall_cnt_o !== 32'd0 || bus.timeout_err_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_regs got cnt=%0d err=%b exp 0/0",
                     bus.stall_cnt_o, bus.timeout_err_o);
        end
        idle_in();
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.stall_o !== 6'b0 || bus.jump_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle got stall=%b jump=%b exp 0/0",
                     bus.stall_o, bus.jump_o);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        bus.ex_is_load_i = 1'b1;
        bus.ex_rd_i = 5'd5;
        bus.id_rs1_i = 5'd5;
        bus.id_rs1_re_i = 1'b1;
        bus.id_rs2_i = 5'd7;
        bus.id_rs2_re_i = 1'b1;
        #1;
        checks++;
        if (bus.stall_o !== 6'b000111) begin
            errors++;
            $display("FAIL lu_rs1 got %b exp 000111", bus.stall_o);
        end
        tick();
        bus.ex_is_load_i = 1'b0;
        #1;
        checks++;
        if (bus.stall_o !== 6'b0) begin
            errors++;
            $display("FAIL lu_bubble got %b exp 000000", bus.stall_o);
        end
        bus.ex_is_load_i = 1'b1;
        bus.ex_rd_i = 5'd0;
        bus.id_rs1_i = 5'd0;
        #1;
        checks++;
        if (bus.stall_o !== 6'b0) begin
            errors++;
            $display("FAIL lu_x0 got %b exp 000000", bus.stall_o);
        end
        bus.ex_rd_i = 5'd9;
        bus.id_rs1_i = 5'd3;
        bus.id_rs2_i = 5'd9;
        #1;
        checks++;
        if (bus.stall_o !== 6'b000111) begin
            errors++;
            $display("FAIL lu_rs2 got %b exp 000111", bus.stall_o);
        end
        bus.id_rs2_re_i = 1'b0;
        #1;
        checks++;
        if (bus.stall_o !== 6'b0) begin
            errors++;
            $display("FAIL lu_no_re got %b exp 000000", bus.stall_o);
        end
        idle_in();
        tick();
        checks++;
        if (bus.stall_cnt_o !== 32'd1) begin
            errors++;
            $display("FAIL lu_cnt got %0d exp 1", bus.stall_cnt_o);
        end
    endtask

    task automatic test_bus_wait();
        do_reset();
        bus.mem_req_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.stall_o !== 6'b011111) begin
                errors++;
                $display("FAIL bus_stall[%0d] got %b exp 011111", i, bus.stall_o);
            end
            tick();
        end
        bus.mem_ack_i = 1'b1;
        #1;
        checks++;
        if (bus.stall_o !== 6'b0) begin
            errors++;
            $display("FAIL bus_ack got %b exp 000000", bus.stall_o);
        end
        tick();
        idle_in();
        checks++;
        if (bus.stall_cnt_o !== 32'd3) begin
            errors++;
            $display("FAIL bus_cnt got %0d exp 3", bus.stall_cnt_o);
        end
    endtask

    task automatic test_deferred_jump();
        do_reset();
        bus.ex_busy_i = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            bus.jump_req_i = (c == 1);
            bus.jump_addr_i = (c == 1) ? 32'h80 : 32'h0;
            #1;
            checks++;
            if (bus.jump_o !== 1'b0 || bus.flush_jump_o !== 1'b0
                || bus.stall_o !== 6'b001111) begin
                errors++;
                $display("FAIL defer_early[%0d] got j=%b f=%b s=%b exp 0 0 001111",
                         c, bus.jump_o, bus.flush_jump_o, bus.stall_o);
            end
            tick();
        end
        idle_in();
        #1;
        checks++;
        if (bus.jump_o !== 1'b1 || bus.flush_jump_o !== 1'b1
            || bus.jump_addr_o !== 32'h80) begin
            errors++;
            $display("FAIL defer_issue got j=%b f=%b a=%h exp 1 1 80",
                     bus.jump_o, bus.flush_jump_o, bus.jump_addr_o);
        end
        tick();
        #1;
        checks++;
        if (bus.jump_o !== 1'b0) begin
            errors++;
            $display("FAIL defer_once got %b exp 0", bus.jump_o);
        end
    endtask

    task automatic test_jump_over_lu();
        do_reset();
        bus.ex_is_load_i = 1'b1;
        bus.ex_rd_i = 5'd5;
        bus.id_rs1_i = 5'd5;
        bus.id_rs1_re_i = 1'b1;
        bus.jump_req_i = 1'b1;
        bus.jump_addr_i = 32'h100;
        #1;
        checks++;
        if (bus.jump_o !== 1'b1 || bus.stall_o !== 6'b0
            || bus.jump_addr_o !== 32'h100) begin
            errors++;
            $display("FAIL jump_lu got j=%b s=%b a=%h exp 1 000000 100",
                     bus.jump_o, bus.stall_o, bus.jump_addr_o);
        end
        tick();
        idle_in();
        bus.mem_req_i = 1'b1;
        bus.mem_ack_i = 1'b1;
        bus.jump_req_i = 1'b1;
        bus.jump_addr_i = 32'h200;
        #1;
        checks++;
        if (bus.jump_o !== 1'b1 || bus.stall_o !== 6'b0
            || bus.jump_addr_o !== 32'h200) begin
            errors++;
            $display("FAIL jump_ack got j=%b s=%b a=%h exp 1 000000 200",
                     bus.jump_o, bus.stall_o, bus.jump_addr_o);
        end
        tick();
        idle_in();
    endtask

    task automatic test_newest_wins();
        do_reset();
        bus.mem_req_i = 1'b1;
        bus.jump_req_i = 1'b1;
        bus.jump_addr_i = 32'h300;
        tick();
        bus.jump_addr_i = 32'h340;
        tick();
        bus.jump_req_i = 1'b0;
        tick();
        bus.mem_req_i = 1'b0;
        #1;
        checks++;
        if (bus.jump_o !== 1'b1 || bus.jump_addr_o !== 32'h340) begin
            errors++;
            $display("FAIL newest got j=%b a=%h exp 1 340",
                     bus.jump_o, bus.jump_addr_o);
        end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        bus.mem_req_i = 1'b1;
        repeat (TO - 1) tick();
        checks++;
        if (bus.timeout_err_o !== 1'b0) begin
            errors++;
            $display("FAIL to_early got %b exp 0", bus.timeout_err_o);
        end
        tick();
        checks++;
        if (bus.timeout_err_o !== 1'b1) begin
            errors++;
            $display("FAIL to_set got %b exp 1", bus.timeout_err_o);
        end
        bus.mem_ack_i = 1'b1;
        tick();
        idle_in();
        tick();
        checks++;
        if (bus.timeout_err_o !== 1'b1) begin
            errors++;
            $display("FAIL to_sticky got %b exp 1", bus.timeout_err_o);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (bus.timeout_err_o !== 1'b0) begin
            errors++;
            $display("FAIL to_reset got %b exp 0", bus.timeout_err_o);
        end
    endtask

    task automatic test_reset_in_pend();
        do_reset();
        bus.ex_busy_i = 1'b1;
        bus.jump_req_i = 1'b1;
        bus.jump_addr_i = 32'h500;
        tick();
        bus.jump_req_i = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        bus.ex_busy_i = 1'b0;
        #1;
        checks++;
        if (bus.jump_o !== 1'b0 || bus.flush_jump_o !== 1'b0) begin
            errors++;
            $display("FAIL pend_drop got j=%b f=%b exp 0 0",
                     bus.jump_o, bus.flush_jump_o);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            bus.ex_is_load_i = $urandom_range(0, 1) == 1;
            bus.ex_rd_i = 5'($urandom_range(0, 3));
            bus.id_rs1_i = 5'($urandom_range(0, 3));
            bus.id_rs2_i = 5'($urandom_range(0, 3));
            bus.id_rs1_re_i = $urandom_range(0, 1) == 1;
            bus.id_rs2_re_i = $urandom_range(0, 1) == 1;
            bus.ex_busy_i = $urandom_range(0, 5) == 0;
            bus.mem_req_i = $urandom_range(0, 2) == 0;
            bus.mem_ack_i = $urandom_range(0, 2) != 0;
            bus.jump_req_i = $urandom_range(0, 4) == 0;
            bus.jump_addr_i = $urandom;
            #1;
            model_eval();
            checks++;
            if (bus.stall_o !== e_stall) begin
                errors++;
                $display("FAIL rnd_stall[%0d] got %b exp %b", n, bus.stall_o, e_stall);
            end
            checks++;
            if (bus.jump_o !== e_jump || bus.flush_jump_o !== e_jump) begin
                errors++;
                $display("FAIL rnd_jump[%0d] got %b%b exp %b",
                         n, bus.jump_o, bus.flush_jump_o, e_jump);
            end
            if (e_jump) begin
                checks++;
                if (bus.jump_addr_o !== e_addr) begin
                    errors++;
                    $display("FAIL rnd_addr[%0d] got %h exp %h", n, bus.jump_addr_o, e_addr);
                end
            end
            tick();
            checks++;
            if (bus.stall_cnt_o !== m_cnt[31:0] || bus.timeout_err_o !== m_err) begin
                errors++;
                $display("FAIL rnd_regs[%0d] got cnt=%0d err=%b exp %0d %b",
                         n, bus.stall_cnt_o, bus.timeout_err_o, m_cnt, m_err);
            end
        end
        rst_n = 1'b1;
        idle_in();
    endtask

    initial begin
        idle_in();
        m_pend = 0; m_tgt = 0; m_run = 0; m_err = 0; m_cnt = 0;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_bus_wait();
        test_deferred_jump();
        test_jump_over_lu();
        test_newest_wins();
        test_timeout();
        test_reset_in_pend();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
